// File: rtl/instruction_decode_pkg.sv
// Shared decode-stage constants: canonical NOP, RV32I opcodes, ALU codes shared with execute,
// and the ID/EX payload structures.
package instruction_decode_pkg;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;

    // Low codes follow {funct7[5], funct3} so R-type decode is a straight concatenation
    localparam logic [3:0]  ALU_ADD    = 4'b0000;
    localparam logic [3:0]  ALU_SLL    = 4'b0001;
    localparam logic [3:0]  ALU_SLT    = 4'b0010;
    localparam logic [3:0]  ALU_SLTU   = 4'b0011;
    localparam logic [3:0]  ALU_XOR    = 4'b0100;
    localparam logic [3:0]  ALU_SRL    = 4'b0101;
    localparam logic [3:0]  ALU_OR     = 4'b0110;
    localparam logic [3:0]  ALU_AND    = 4'b0111;
    localparam logic [3:0]  ALU_SUB    = 4'b1000;
    localparam logic [3:0]  ALU_PASSB  = 4'b1001;
    localparam logic [3:0]  ALU_SRA    = 4'b1101;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        ctrl_t       ctrl;
    } id_ex_t;

    // Equality branches compare by subtraction, ordered branches by set-less-than
    function automatic logic [3:0] branch_alu(input logic [2:0] funct3);
        case (funct3)
            3'b100, 3'b101: branch_alu = ALU_SLT;
            3'b110, 3'b111: branch_alu = ALU_SLTU;
            default:        branch_alu = ALU_SUB;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Decode-stage bus: fetch/hazard/writeback inputs and the ID/EX outputs toward execute.
// master = surrounding pipeline, slave = instruction_decode.
interface instruction_decode_if;
    logic [31:0] instruction_addr_i;
    logic [31:0] instruction_i;
    logic        PCSrc_i;
    logic        stall_en_i;
    logic        wb_reg_write_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_data_i;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [31:0] ex_pc_o;
    logic [31:0] ex_rs1_data_o;
    logic [31:0] ex_rs2_data_o;
    logic [31:0] ex_imm_o;
    logic [4:0]  ex_rs1_addr_o;
    logic [4:0]  ex_rs2_addr_o;
    logic [4:0]  ex_rd_addr_o;
    logic [3:0]  ex_alu_ctrl_o;
    logic        ex_alu_src_o;
    logic        ex_branch_o;
    logic        ex_jump_o;
    logic        ex_mem_read_o;
    logic        ex_mem_write_o;
    logic        ex_mem_to_reg_o;
    logic        ex_reg_write_o;

    modport master (
        output instruction_addr_i, instruction_i, PCSrc_i, stall_en_i,
               wb_reg_write_i, wb_rd_addr_i, wb_rd_data_i,
        input  rs1_addr_o, rs2_addr_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_alu_ctrl_o, ex_alu_src_o,
               ex_branch_o, ex_jump_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
               ex_reg_write_o
    );

    modport slave (
        input  instruction_addr_i, instruction_i, PCSrc_i, stall_en_i,
               wb_reg_write_i, wb_rd_addr_i, wb_rd_data_i,
        output rs1_addr_o, rs2_addr_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_alu_ctrl_o, ex_alu_src_o,
               ex_branch_o, ex_jump_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
               ex_reg_write_o
    );
endinterface

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two async read ports, one sync write port, x0 hardwired to zero.
// WB_BYPASS_EN: a same-cycle writeback to a read address is forwarded to that read port.
module register_file (
    input  logic        i_clk,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_we,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);
    logic [31:0] r_regs [0:31];
    logic        w_wr_act;
    logic        w_hit1;
    logic        w_hit2;

    assign w_wr_act = i_we && (i_wr_addr != 5'd0);

    always_ff @(posedge i_clk) begin
        if (w_wr_act) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef WB_BYPASS_EN
    assign w_hit1 = w_wr_act && (i_wr_addr == i_rs1_addr);
    assign w_hit2 = w_wr_act && (i_wr_addr == i_rs2_addr);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'd0 : (w_hit1 ? i_wr_data : r_regs[i_rs1_addr]);
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'd0 : (w_hit2 ? i_wr_data : r_regs[i_rs2_addr]);

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: IF/ID register, inline decode + immediate gen, register file read, ID/EX register.
// Latency: fetch to EX outputs is 2 edges; rs1/rs2 addresses are combinational from IF/ID.
// Backpressure: stall holds IF/ID and issues a bubble; flush (priority) loads NOP and a bubble. Optional WB_BYPASS_EN.
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic                 sys_clk_i,
    input  logic                 rst_n_i,
    instruction_decode_if.slave  id_bus
);
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    id_ex_t      r_ex;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7_5;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    ctrl_t       w_ctrl;
    logic [31:0] w_imm;
    logic        w_legal;
    id_ex_t      w_ex;

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i || id_bus.PCSrc_i) begin
            r_id_pc   <= 32'd0;
            r_id_inst <= INST_NOP;
        end else if (!id_bus.stall_en_i) begin
            r_id_pc   <= id_bus.instruction_addr_i;
            r_id_inst <= id_bus.instruction_i;
        end
    end

    assign w_opcode   = r_id_inst[6:0];
    assign w_funct3   = r_id_inst[14:12];
    assign w_funct7_5 = r_id_inst[30];
    assign w_rs1      = r_id_inst[19:15];
    assign w_rs2      = r_id_inst[24:20];
    assign w_rd       = r_id_inst[11:7];

    assign w_imm_i = {{20{r_id_inst[31]}}, r_id_inst[31:20]};
    assign w_imm_s = {{20{r_id_inst[31]}}, r_id_inst[31:25], r_id_inst[11:7]};
    assign w_imm_b = {{19{r_id_inst[31]}}, r_id_inst[31], r_id_inst[7], r_id_inst[30:25], r_id_inst[11:8], 1'b0};
    assign w_imm_j = {{11{r_id_inst[31]}}, r_id_inst[31], r_id_inst[19:12], r_id_inst[20], r_id_inst[30:21], 1'b0};
    assign w_imm_u = {r_id_inst[31:12], 12'd0};

    assign id_bus.rs1_addr_o = w_rs1;
    assign id_bus.rs2_addr_o = w_rs2;

    register_file u_register_file (
        .i_clk      (sys_clk_i),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (id_bus.wb_reg_write_i),
        .i_wr_addr  (id_bus.wb_rd_addr_i),
        .i_wr_data  (id_bus.wb_rd_data_i)
    );

    always_comb begin
        w_ctrl  = '0;
        w_imm   = 32'd0;
        w_legal = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                w_ctrl.alu_ctrl  = {w_funct7_5, w_funct3};
                w_ctrl.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                w_imm            = w_imm_i;
                w_ctrl.alu_ctrl  = {(w_funct3 == 3'b101) && w_funct7_5, w_funct3};
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                w_imm             = w_imm_i;
                w_ctrl.alu_ctrl   = ALU_ADD;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            OPC_STORE: begin
                w_imm            = w_imm_s;
                w_ctrl.alu_ctrl  = ALU_ADD;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm           = w_imm_b;
                w_ctrl.alu_ctrl = branch_alu(w_funct3);
                w_ctrl.branch   = 1'b1;
            end
            OPC_JAL: begin
                w_imm            = w_imm_j;
                w_ctrl.alu_ctrl  = ALU_ADD;
                w_ctrl.jump      = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_LUI: begin
                w_imm            = w_imm_u;
                w_ctrl.alu_ctrl  = ALU_PASSB;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        // The canonical NOP (flush/reset filler) travels as an all-zero bubble
        if (r_id_inst == INST_NOP) begin
            w_legal = 1'b0;
        end
    end

    always_comb begin
        w_ex = '0;
        if (w_legal) begin
            w_ex.pc       = r_id_pc;
            w_ex.rs1_data = w_rs1_data;
            w_ex.rs2_data = w_rs2_data;
            w_ex.imm      = w_imm;
            w_ex.rs1_addr = w_rs1;
            w_ex.rs2_addr = w_rs2;
            w_ex.rd_addr  = w_rd;
            w_ex.ctrl     = w_ctrl;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i || id_bus.PCSrc_i || id_bus.stall_en_i) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_ex;
        end
    end

    assign id_bus.ex_pc_o         = r_ex.pc;
    assign id_bus.ex_rs1_data_o   = r_ex.rs1_data;
    assign id_bus.ex_rs2_data_o   = r_ex.rs2_data;
    assign id_bus.ex_imm_o        = r_ex.imm;
    assign id_bus.ex_rs1_addr_o   = r_ex.rs1_addr;
    assign id_bus.ex_rs2_addr_o   = r_ex.rs2_addr;
    assign id_bus.ex_rd_addr_o    = r_ex.rd_addr;
    assign id_bus.ex_alu_ctrl_o   = r_ex.ctrl.alu_ctrl;
    assign id_bus.ex_alu_src_o    = r_ex.ctrl.alu_src;
    assign id_bus.ex_branch_o     = r_ex.ctrl.branch;
    assign id_bus.ex_jump_o       = r_ex.ctrl.jump;
    assign id_bus.ex_mem_read_o   = r_ex.ctrl.mem_read;
    assign id_bus.ex_mem_write_o  = r_ex.ctrl.mem_write;
    assign id_bus.ex_mem_to_reg_o = r_ex.ctrl.mem_to_reg;
    assign id_bus.ex_reg_write_o  = r_ex.ctrl.reg_write;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: expected ID/EX bundles are queued as each cycle is driven
// and popped/compared one time unit after the edge that produces them.
module tb_instruction_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
        logic [3:0]  alu;
        logic [6:0]  ctl;   // {alu_src, branch, jump, mem_read, mem_write, mem_to_reg, reg_write}
    } exp_t;

    localparam logic [6:0] C_R   = 7'b0000001;
    localparam logic [6:0] C_I   = 7'b1000001;
    localparam logic [6:0] C_LD  = 7'b1001011;
    localparam logic [6:0] C_ST  = 7'b1000100;
    localparam logic [6:0] C_BR  = 7'b0100000;
    localparam logic [6:0] C_J   = 7'b0010001;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam exp_t BUBBLE      = '0;

    logic        sys_clk_i = 1'b0;
    logic        rst_n_i;
    exp_t        q[$];
    logic [31:0] rf [0:31];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    always #5 sys_clk_i = ~sys_clk_i;

    instruction_decode_if u_if ();

    instruction_decode dut (
        .sys_clk_i (sys_clk_i),
        .rst_n_i   (rst_n_i),
        .id_bus    (u_if)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] imm,
                                input logic [3:0] alu, input logic [6:0] ctl);
        exp_t e;
        e.pc   = pc;
        e.rs1a = inst[19:15];
        e.rs2a = inst[24:20];
        e.rda  = inst[11:7];
        e.rs1d = rf[inst[19:15]];
        e.rs2d = rf[inst[24:20]];
        e.imm  = imm;
        e.alu  = alu;
        e.ctl  = ctl;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.pc   = u_if.ex_pc_o;
        o.rs1d = u_if.ex_rs1_data_o;
        o.rs2d = u_if.ex_rs2_data_o;
        o.imm  = u_if.ex_imm_o;
        o.rs1a = u_if.ex_rs1_addr_o;
        o.rs2a = u_if.ex_rs2_addr_o;
        o.rda  = u_if.ex_rd_addr_o;
        o.alu  = u_if.ex_alu_ctrl_o;
        o.ctl  = {u_if.ex_alu_src_o, u_if.ex_branch_o, u_if.ex_jump_o, u_if.ex_mem_read_o,
                  u_if.ex_mem_write_o, u_if.ex_mem_to_reg_o, u_if.ex_reg_write_o};
        return o;
    endfunction

    task automatic chk_ex(input string tag);
        exp_t e;
        exp_t o;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, observed());
        end else begin
            e = q.pop_front();
            o = observed();
            assert (o === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, o, e);
            end
        end
    endtask

    task automatic chk_addr(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] inst,
                        input logic stall, input logic flush, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input exp_t e, input string tag);
        rst_n_i                 = rst;
        u_if.instruction_addr_i = pc;
        u_if.instruction_i      = inst;
        u_if.stall_en_i         = stall;
        u_if.PCSrc_i            = flush;
        u_if.wb_reg_write_i     = we;
        u_if.wb_rd_addr_i       = wa;
        u_if.wb_rd_data_i       = wd;
        q.push_back(e);
        @(posedge sys_clk_i);
        #1;
        if (we && wa != 5'd0) rf[wa] = wd;
        chk_ex(tag);
    endtask

    initial begin
        exp_t e;
        rf[0] = 32'd0;

        // Reset, while seeding x1..x31 with known values through writeback
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 32'd0, 32'h0050_0093, 1'b0, 1'b0, i != 0, i[4:0], 32'hA000_0000 | i, BUBBLE, "reset_bubble");
        end
        chk_addr("reset_rs1_addr", u_if.rs1_addr_o, 5'd0);
        chk_addr("reset_rs2_addr", u_if.rs2_addr_o, 5'd0);

        // addi x1,x0,5 at PC 0
        step(1'b1, 32'd0, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, BUBBLE, "fetch_addi");
        chk_addr("addi_rs1_addr", u_if.rs1_addr_o, 5'd0);
        chk_addr("addi_rs2_addr", u_if.rs2_addr_o, 5'd5);
        step(1'b1, 32'd4, NOP, 1'b0, 1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF,
             mk(32'd0, 32'h0050_0093, 32'd5, 4'h0, C_I), "addi_ex");

        // add x3,x2,x2 after writing x2, then sra x4,x2,x1
        step(1'b1, 32'd8, 32'h0021_01B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, BUBBLE, "nop_ex");
        step(1'b1, 32'd12, 32'h4011_5233, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(32'd8, 32'h0021_01B3, 32'd0, 4'h0, C_R), "add_ex");
        step(1'b1, 32'd16, 32'h0002_8333, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(32'd12, 32'h4011_5233, 32'd0, 4'hD, C_R), "sra_ex");

        // add x6,x5,x0 in IF/ID while x5 is written back
        e = mk(32'd16, 32'h0002_8333, 32'd0, 4'h0, C_R);
`ifdef WB_BYPASS_EN
        e.rs1d = 32'h0000_1234;
`endif
        step(1'b1, 32'd20, NOP, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, e, "bypass_ex");

        // lw x7,8(x1) stalled for one cycle
        step(1'b1, 32'd24, 32'h0080_A383, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, BUBBLE, "nop_ex2");
        step(1'b1, 32'd28, 32'h0010_0493, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, BUBBLE, "stall_bubble");
        chk_addr("stall_hold_rs1", u_if.rs1_addr_o, 5'd1);
        chk_addr("stall_hold_rs2", u_if.rs2_addr_o, 5'd8);
        step(1'b1, 32'd28, 32'h0010_0493, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(32'd24, 32'h0080_A383, 32'd8, 4'h0, C_LD), "lw_after_stall");

        // Flush together with stall: two bubbles reach EX
        step(1'b1, 32'd32, 32'h0020_C863, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, BUBBLE, "flush_bubble1");
        chk_addr("flush_rs1_addr", u_if.rs1_addr_o, 5'd0);
        chk_addr("flush_rs2_addr", u_if.rs2_addr_o, 5'd0);
        step(1'b1, 32'd36, 32'h0020_C863, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, BUBBLE, "flush_bubble2");

        // blt, jal with negative offset, lui, sw x0,-4 after x0 write attempts, srai
        step(1'b1, 32'd40, 32'hFF9F_F0EF, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(32'd36, 32'h0020_C863, 32'd16, 4'h2, C_BR), "blt_ex");
        step(1'b1, 32'd44, 32'h1234_5537, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(32'd40, 32'hFF9F_F0EF, 32'hFFFF_FFF8, 4'h0, C_J), "jal_ex");
        step(1'b1, 32'd48, 32'hFE00_2E23, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF,
             mk(32'd44, 32'h1234_5537, 32'h1234_5000, 4'h9, C_I), "lui_ex");
        step(1'b1, 32'd52, 32'h4031_5593, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF,
             mk(32'd48, 32'hFE00_2E23, 32'hFFFF_FFFC, 4'h0, C_ST), "sw_x0_ex");
        step(1'b1, 32'd56, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
             mk(32'd52, 32'h4031_5593, 32'h0000_0403, 4'hD, C_I), "srai_ex");
        step(1'b1, 32'd60, 32'h0080_A383, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, BUBBLE, "illegal_bubble");
        chk_addr("lw_in_ifid_rs1", u_if.rs1_addr_o, 5'd1);

        // Reset mid-operation with stall asserted
        step(1'b0, 32'd64, 32'h0080_A383, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, BUBBLE, "midreset_bubble");
        chk_addr("midreset_rs1", u_if.rs1_addr_o, 5'd0);
        chk_addr("midreset_rs2", u_if.rs2_addr_o, 5'd0);
        step(1'b1, 32'd0, NOP, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, BUBBLE, "post_reset_bubble");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
